// File: rtl/demux_alternador_pkg.sv
// Shared definitions for the demux_alternador block: selector state encoding
// and default widths. The optional per-lane word counters are enabled by
// defining the macro DEMUX_CNT_EN.
package demux_alternador_pkg;

    localparam int DEF_BUS_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 8;

    // Lane the next accepted word is steered to.
    typedef enum logic {
        SEL0 = 1'b0,
        SEL1 = 1'b1
    } selState_t;

endpackage

// File: rtl/demux_alternador_lane_reg.sv
// One output lane of demux_alternador: a single registered word with
// valid/ready, plus an optional transfer counter (macro DEMUX_CNT_EN).
// The lane reports canLoad so the parent only loads when the slot is free
// or is being emptied in the same cycle.
module demux_alternador_lane_reg
    import demux_alternador_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] loadData,
    input  logic                 readyIn,
    output logic                 canLoad,
    output logic [BUS_WIDTH-1:0] dataOut,
    output logic                 validOut
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] count
`endif
);

    // Slot is free, or the consumer is draining it this cycle.
    assign canLoad = ~validOut | readyIn;

    // Word register: a load wins over a drain so back-to-back words see no bubble.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dataOut  <= '0;
            validOut <= 1'b0;
        end else if (load) begin
            dataOut  <= loadData;
            validOut <= 1'b1;
        end else if (readyIn) begin
            validOut <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    // Count completed output transfers; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (validOut && readyIn) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_alternador.sv
// 1-to-2 alternating demultiplexer. Input words are steered to lane 0, lane 1,
// lane 0, ... and each lane has its own output register, so a stalled lane
// only stalls the input when it is that lane's turn.
// Optional per-lane transfer counters count0/count1: macro DEMUX_CNT_EN.
//
// Handshake: a word moves across an interface in a cycle where valid and
// ready are both 1 at the rising edge. A source holding valid=1 keeps its
// data stable until that happens; ready never depends on valid.
module demux_alternador
    import demux_alternador_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [BUS_WIDTH-1:0] data_out0,
    output logic                 valid_out0,
    input  logic                 ready_in0,
    output logic [BUS_WIDTH-1:0] data_out1,
    output logic                 valid_out1,
    input  logic                 ready_in1,
`ifdef DEMUX_CNT_EN
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1,
`endif
    output logic                 selector
);

    selState_t state;
    logic      canLoad0;
    logic      canLoad1;
    logic      accept;
    logic      load0;
    logic      load1;

    // ready_out follows only the selected lane's free-slot status.
    assign ready_out = (state == SEL0) ? canLoad0 : canLoad1;
    assign accept    = valid_in & ready_out;
    assign load0     = accept & (state == SEL0);
    assign load1     = accept & (state == SEL1);

    // The selector output is the FSM state itself, visible for debug.
    assign selector  = state;

    // Selector FSM: every accepted word hands the next turn to the other lane.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= SEL0;
        end else if (accept) begin
            case (state)
                SEL0:    state <= SEL1;
                SEL1:    state <= SEL0;
                default: state <= SEL0;
            endcase
        end
    end

    demux_alternador_lane_reg #(
        .BUS_WIDTH (BUS_WIDTH)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_WIDTH (CNT_WIDTH)
`endif
    ) lane0 (
        .clk      (clk),
        .reset_L  (reset_L),
        .load     (load0),
        .loadData (data_in),
        .readyIn  (ready_in0),
        .canLoad  (canLoad0),
        .dataOut  (data_out0),
        .validOut (valid_out0)
`ifdef DEMUX_CNT_EN
        ,
        .count    (count0)
`endif
    );

    demux_alternador_lane_reg #(
        .BUS_WIDTH (BUS_WIDTH)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_WIDTH (CNT_WIDTH)
`endif
    ) lane1 (
        .clk      (clk),
        .reset_L  (reset_L),
        .load     (load1),
        .loadData (data_in),
        .readyIn  (ready_in1),
        .canLoad  (canLoad1),
        .dataOut  (data_out1),
        .validOut (valid_out1)
`ifdef DEMUX_CNT_EN
        ,
        .count    (count1)
`endif
    );

endmodule
